uart_loader: RTL and testbench

- Serial program loader that sits directly upstream of the shared program memory and is an alternative source for the program-mode write port.
- Receives a framed byte stream on a UART RX pin and emits the same address/data/write-enable write transactions as the button-driven memory programmer.
- Lets an entire CDEC8 program be loaded from a host.
- The shell muxes its outputs onto the memory port when mode=1 and the loader is enabled.

---
 rtl/uart_loader_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 106 ++++++++++
 rtl/uart_loader.sv | 143 ++++++++++++++
 tb/tb_uart_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
//   LOADER_START_BYTE    : frame header value
//   DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud
//   loader_state_t       : loader FSM states (2-bit)
//   rx_state_t           : byte receiver states (2-bit)
package uart_loader_pkg;

  localparam logic [7:0] LOADER_START_BYTE    = 8'hA5;
  localparam int         DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, bit timer, bit counter and
// LSB-first shift register.
// Ports:
//   i_clk        : system clock
//   i_rst_n      : synchronous active-low reset
//   i_clear      : synchronous receiver reset (loader disabled)
//   i_rx         : asynchronous RX line, idle high
//   o_byte_out   : last received byte, valid with o_byte_valid
//   o_byte_valid : 1-cycle pulse, byte received with good stop bit
//   o_frame_err  : 1-cycle pulse, stop bit sampled low
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_rx,
  output logic [7:0] o_byte_out,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     r_state, w_state;
  logic          r_rx_s1, r_rx_s2, r_rx_d;
  logic [CW-1:0] r_tick, w_tick;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic          r_valid, w_valid;
  logic          r_ferr, w_ferr;

  always_comb begin
    w_state = r_state;
    w_tick  = r_tick + 1'b1;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_tick = '0;
        // falling edge of the synchronized line
        if (r_rx_d && !r_rx_s2) w_state = RX_START;
      end
      RX_START: begin
        // mid start bit: a high line here was only a glitch
        if (r_tick == HALF_TICK) begin
          w_tick  = '0;
          w_bit   = '0;
          w_state = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_tick == LAST_TICK) begin
          w_tick  = '0;
          w_shift = {r_rx_s2, r_shift[7:1]};
          w_bit   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_tick == LAST_TICK) begin
          w_tick  = '0;
          w_state = RX_IDLE;
          if (r_rx_s2) w_valid = 1'b1;
          else         w_ferr  = 1'b1;
        end
      end
      default: w_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_state <= RX_IDLE;
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      r_state <= w_state;
      r_tick  <= w_tick;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
    end
  end

  assign o_byte_out   = r_shift;
  assign o_byte_valid = r_valid;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/uart_loader.sv
// Serial program loader: receives frames {START_BYTE, LEN, DATA x LEN, CSUM}
// over UART and issues program-memory write strobes.
// Ports:
//   clock       : system clock
//   reset_N     : synchronous active-low reset
//   enable      : loader active; low forces IDLE and suppresses writes
//   rx          : asynchronous UART RX line, idle high
//   address_out : memory write address
//   data_out    : memory write data (holds between strobes)
//   wr_en_out   : 1-cycle write strobe
//   busy        : frame in progress
//   done        : last frame loaded with good checksum (sticky)
//   error       : last frame failed, checksum or framing (sticky)
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0] START_BYTE   = LOADER_START_BYTE
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] address_out,
  output logic [7:0] data_out,
  output logic       wr_en_out,
  output logic       busy,
  output logic       done,
  output logic       error
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (clock),
    .i_rst_n     (reset_N),
    .i_clear     (!enable),
    .i_rx        (rx),
    .o_byte_out  (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );

  loader_state_t r_state, w_next_state;
  logic [7:0]    r_addr, w_addr;
  logic [7:0]    r_data, w_data;
  logic          r_wr_en, w_wr_en;
  logic          r_done, w_done;
  logic          r_error, w_error;
  logic [7:0]    r_csum, w_csum;
  // 9 bits so a length byte of 0 can stand for 256
  logic [8:0]    r_count, w_count;

  always_comb begin
    w_next_state = r_state;
    // address advances the cycle after each strobe
    w_addr  = r_wr_en ? r_addr + 8'd1 : r_addr;
    w_data  = r_data;
    w_wr_en = 1'b0;
    w_done  = r_done;
    w_error = r_error;
    w_csum  = r_csum;
    w_count = r_count;
    if (!enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte_valid && w_byte == START_BYTE) begin
            w_next_state = ST_LEN;
            w_done       = 1'b0;
            w_error      = 1'b0;
            w_csum       = '0;
            w_addr       = '0;
          end
        end
        ST_LEN: begin
          if (w_byte_valid) begin
            w_count      = (w_byte == 8'd0) ? 9'd256 : {1'b0, w_byte};
            w_next_state = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_byte_valid) begin
            w_wr_en = 1'b1;
            w_data  = w_byte;
            w_csum  = r_csum + w_byte;
            w_count = r_count - 9'd1;
            if (r_count == 9'd1) w_next_state = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (w_byte_valid) begin
            if (w_byte == r_csum) w_done  = 1'b1;
            else                  w_error = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
      // framing errors only matter inside a frame
      if (w_frame_err && r_state != ST_IDLE) begin
        w_error      = 1'b1;
        w_next_state = ST_IDLE;
        w_wr_en      = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_csum  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_wr_en <= w_wr_en;
      r_done  <= w_done;
      r_error <= w_error;
      r_csum  <= w_csum;
      r_count <= w_count;
    end
  end

  assign address_out = r_addr;
  assign data_out    = r_data;
  assign wr_en_out   = r_wr_en;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign error       = r_error;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader at CLKS_PER_BIT=16.
module tb_uart_loader;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset_N;
  logic       enable;
  logic       rx;
  logic [7:0] address_out;
  logic [7:0] data_out;
  logic       wr_en_out;
  logic       busy;
  logic       done;
  logic       error;

  uart_loader #(
    .CLKS_PER_BIT(CPB),
    .START_BYTE  (8'hA5)
  ) dut (
    .clock      (clock),
    .reset_N    (reset_N),
    .enable     (enable),
    .rx         (rx),
    .address_out(address_out),
    .data_out   (data_out),
    .wr_en_out  (wr_en_out),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic        in_stop  = 1'b0;
  logic        prev_wr  = 1'b0;
  logic [7:0]  prev_addr = 8'h00;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the next queued {addr,data}, fall inside
  // the stop bit of its byte, last one cycle, and be followed by addr+1.
  always @(negedge clock) begin
    logic [15:0] e;
    logic [7:0]  nxt;
    if (prev_wr) begin
      nxt = prev_addr + 8'd1;
      check("strobe_width", {15'd0, wr_en_out}, 16'd0);
      check("addr_incr", {8'd0, address_out}, {8'd0, nxt});
    end
    if (wr_en_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got %h/%h expected none at %0t", address_out, data_out, $time);
      end else begin
        e = exp_q.pop_front();
        check("write", {address_out, data_out}, e);
      end
      check("strobe_in_stop", {15'd0, in_stop}, 16'd1);
    end
    prev_wr   = (wr_en_out === 1'b1);
    prev_addr = address_out;
  end

  task automatic hold_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    hold_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_bit(b[i], CPB);
    in_stop = 1'b1;
    hold_bit(stop_bit, CPB);
    in_stop = 1'b0;
    hold_bit(1'b1, 2);
  endtask

  task automatic send_data(input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back({a, b});
    send_byte(b, 1'b1);
  endtask

  task automatic check_status(input string tag, input logic b, input logic d, input logic er);
    check({tag, "_busy"},  {15'd0, busy},  {15'd0, b});
    check({tag, "_done"},  {15'd0, done},  {15'd0, d});
    check({tag, "_error"}, {15'd0, error}, {15'd0, er});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"},  {8'd0, address_out}, 16'h0000);
    check({tag, "_data"},  {8'd0, data_out},    16'h0000);
    check({tag, "_wr_en"}, {15'd0, wr_en_out},  16'h0000);
    check_status(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pending"}, exp_q.size()[15:0], 16'd0);
    exp_q.delete();
  endtask

  initial begin
    rx      = 1'b1;
    enable  = 1'b1;
    reset_N = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("reset");
    reset_N = 1'b1;
    hold_bit(1'b1, 4);

    // Normal load of three bytes, checksum 66
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    check("load_busy_mid", {15'd0, busy}, 16'd1);
    send_data(8'h00, 8'h11);
    send_data(8'h01, 8'h22);
    send_data(8'h02, 8'h33);
    send_byte(8'h66, 1'b1);
    hold_bit(1'b1, 4);
    check_status("load", 1'b0, 1'b1, 1'b0);
    check("load_addr", {8'd0, address_out}, 16'h0003);
    check("load_data_hold", {8'd0, data_out}, 16'h0033);
    check_drained("load");

    // Bad checksum: 10+20 = 30, 31 sent
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_data(8'h00, 8'h10);
    send_data(8'h01, 8'h20);
    send_byte(8'h31, 1'b1);
    hold_bit(1'b1, 4);
    check_status("badsum", 1'b0, 1'b0, 1'b1);
    check_drained("badsum");

    // Length 0 means 256 bytes; sum of 00..FF = 7F80 -> 80
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) send_data(i[7:0], i[7:0]);
    send_byte(8'h80, 1'b1);
    hold_bit(1'b1, 4);
    check_status("len256", 1'b0, 1'b1, 1'b0);
    check("len256_addr_wrap", {8'd0, address_out}, 16'h0000);
    check_drained("len256");

    // Framing error mid-frame, then a clean frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_data(8'h00, 8'h44);
    send_byte(8'h12, 1'b0);
    hold_bit(1'b1, 4);
    check_status("framing", 1'b0, 1'b0, 1'b1);
    check_drained("framing");
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_data(8'h00, 8'h55);
    send_byte(8'h55, 1'b1);
    hold_bit(1'b1, 4);
    check_status("after_framing", 1'b0, 1'b1, 1'b0);
    check_drained("after_framing");

    // Noise bytes in IDLE and a short glitch: nothing happens
    send_byte(8'h00, 1'b1);
    send_byte(8'h7F, 1'b1);
    hold_bit(1'b0, CPB / 4);
    hold_bit(1'b1, 3 * CPB);
    check_status("noise", 1'b0, 1'b1, 1'b0);
    check_drained("noise");
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_data(8'h00, 8'h01);
    send_data(8'h01, 8'h02);
    send_byte(8'h03, 1'b1);
    hold_bit(1'b1, 4);
    check_status("after_noise", 1'b0, 1'b1, 1'b0);
    check("after_noise_addr", {8'd0, address_out}, 16'h0002);
    check_drained("after_noise");

    // Enable dropped after the first data byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_data(8'h00, 8'hAA);
    enable = 1'b0;
    hold_bit(1'b1, 5);
    enable = 1'b1;
    check_status("enable_abort", 1'b0, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    hold_bit(1'b1, 4);
    check_status("enable_abort_after", 1'b0, 1'b0, 1'b0);
    check_drained("enable_abort");

    // Reset pulse mid-frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_data(8'h00, 8'hDD);
    reset_N = 1'b0;
    @(posedge clock);
    #1;
    reset_N = 1'b1;
    check_reset_state("reset_abort");
    send_byte(8'hEE, 1'b1);
    hold_bit(1'b1, 4);
    check_reset_state("reset_abort_after");
    check_drained("reset_abort");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
